// File: rtl/uvml_st_rx_fifo.sv
// uvml_st_rx_fifo: link receiver that captures enabled bytes into a show-ahead FIFO and counts overflow drops (optional rx_byte_cnt via UVML_ST_RX_FIFO_BYTE_CNT_EN)
module uvml_st_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [7:0]               data,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_ovf
`ifdef UVML_ST_RX_FIFO_BYTE_CNT_EN
  ,
  output logic [31:0]              rx_byte_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic             cap_vld_q;
  logic [7:0]       cap_data_q;
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             full, pop, push, drop;
  assign out_valid = level_q != '0;
  assign out_data  = out_valid ? mem_q[rptr_q] : 8'h00;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;
  // a pop frees a slot on the same edge, so a full FIFO still accepts a byte when it is being read
  always_comb begin
    full    = level_q == (AW+1)'(DEPTH);
    pop     = out_valid & out_ready;
    push    = cap_vld_q & (!full | pop);
    drop    = cap_vld_q & full & !pop;
    level_d = (push && !pop) ? level_q + 1'b1 : (!push && pop) ? level_q - 1'b1 : level_q;
    ovf_d   = clr_ovf ? drop : (ovf_q | drop);
    drop_d  = clr_ovf ? CNT_W'(drop) : (drop && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
  end
  // capture stage, pointers, occupancy and overflow bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_vld_q  <= 1'b0;
      cap_data_q <= 8'h00;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      cap_vld_q  <= enable;
      cap_data_q <= data;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end
  // storage needs no reset: out_data is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wptr_q] <= cap_data_q;
  end
`ifdef UVML_ST_RX_FIFO_BYTE_CNT_EN
  logic [31:0] byte_cnt_q;
  assign rx_byte_cnt = byte_cnt_q;
  // counts accepted bytes only; wraps and ignores clr_ovf
  always_ff @(posedge clk) begin
    if (reset) byte_cnt_q <= '0;
    else if (push) byte_cnt_q <= byte_cnt_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_uvml_st_rx_fifo.sv
// tb_uvml_st_rx_fifo: directed and random checks of uvml_st_rx_fifo against a queue-based model
module tb_uvml_st_rx_fifo;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [7:0] data = 8'h00;
  logic out_valid, overflow;
  logic [7:0] out_data;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0] drop_cnt;
`ifdef UVML_ST_RX_FIFO_BYTE_CNT_EN
  logic [31:0] rx_byte_cnt;
`endif
  int checks = 0, errors = 0;
  byte unsigned q[$];
  bit m_cv, m_ovf;
  byte unsigned m_cd;
  int m_cnt, m_bytes;

  uvml_st_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .data(data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
`ifdef UVML_ST_RX_FIFO_BYTE_CNT_EN
    , .rx_byte_cnt(rx_byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit en, input byte unsigned d, input bit rdy, input bit clr, input bit rst);
    bit drp;
    drp = 1'b0;
    enable = en; data = d; out_ready = rdy; clr_ovf = clr; reset = rst;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_cv = 0; m_cd = 0; m_ovf = 0; m_cnt = 0; m_bytes = 0;
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (m_cv) begin
        if (q.size() < DEPTH) begin q.push_back(m_cd); m_bytes++; end
        else drp = 1'b1;
      end
      if (clr) begin m_ovf = drp; m_cnt = drp ? 1 : 0; end
      else if (drp) begin m_ovf = 1; m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1; end
      m_cv = en; m_cd = d;
    end
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_data", out_data, q.size() != 0 ? q[0] : 8'h00);
    chk("level", level, q.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_cnt);
`ifdef UVML_ST_RX_FIFO_BYTE_CNT_EN
    chk("rx_byte_cnt", rx_byte_cnt, m_bytes);
`endif
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", drop_cnt, 0);
    step(1, 8'hA5, 1, 0, 0);
    chk("single_cap_valid", out_valid, 0);
    step(0, 0, 1, 0, 0);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    chk("single_level1", level, 1);
    step(0, 0, 1, 0, 0);
    chk("single_level0", level, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("burst_level", level, 8);
    chk("burst_head", out_data, 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk("burst_order", out_data, i);
      step(0, 0, 1, 0, 0);
    end
    chk("burst_empty", level, 0);
    chk("burst_no_ovf", overflow, 0);
    for (int i = 0; i < 11; i++) step(1, i < 8 ? 8'(8'h20 + i) : 8'(8'h10 + i - 8), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt", drop_cnt, 3);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", out_data, 8'h20 + i);
      step(0, 0, 1, 0, 0);
    end
    chk("ovf_drain_empty", level, 0);
    step(0, 0, 0, 1, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_cnt", drop_cnt, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 8'h55, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("fullpop_level", level, 8);
    chk("fullpop_no_ovf", overflow, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    chk("fullpop_last", out_data, 8'h55);
    chk("fullpop_level1", level, 1);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
    chk("race_cnt5", drop_cnt, 5);
    step(0, 0, 0, 1, 0);
    chk("race_ovf", overflow, 1);
    chk("race_cnt1", drop_cnt, 1);
    step(0, 0, 0, 1, 0);
    chk("race_clr_ovf", overflow, 0);
    chk("race_clr_cnt", drop_cnt, 0);
    for (int i = 0; i < 20; i++) step(1, 8'(i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("sat_cnt", drop_cnt, 15);
    chk("sat_ovf", overflow, 1);
    chk("sat_level", level, 8);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("mid_level4", level, 4);
    step(1, 8'h99, 0, 0, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", level, 0);
    step(1, 8'h3C, 1, 0, 0);
    chk("mid_inflight_gone", out_valid, 0);
    step(0, 0, 1, 0, 0);
    chk("mid_next", out_data, 8'h3C);
    chk("mid_next_level", level, 1);
    step(0, 0, 1, 0, 0);
    chk("mid_alone", out_valid, 0);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 99) < 70, 8'($urandom),
           $urandom_range(0, 99) < (((k / 400) % 2) != 0 ? 85 : 20),
           $urandom_range(0, 99) < 3, $urandom_range(0, 999) < 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
